// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched ops, snoops both CDBs, issues the lowest ready entry.
// Optional macro RS_BYPASS_EN: a ready dispatch skips the buffer when no stored entry is ready.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              enable_from_dispatcher,
  input  logic [OP_W-1:0]   op_enum_from_dispatcher,
  input  logic [DATA_W-1:0] V1_from_dispatcher,
  input  logic [DATA_W-1:0] V2_from_dispatcher,
  input  logic [ROB_W-1:0]  Q1_from_dispatcher,
  input  logic [ROB_W-1:0]  Q2_from_dispatcher,
  input  logic [DATA_W-1:0] imm_from_dispatcher,
  input  logic [DATA_W-1:0] inst_pos_from_dispatcher,
  input  logic [ROB_W-1:0]  rob_id_from_dispatcher,
  output logic              is_full_to_dispatcher,
  input  logic              enable_from_alu,
  input  logic [ROB_W-1:0]  rob_id_from_alu,
  input  logic [DATA_W-1:0] result_from_alu,
  input  logic              enable_from_lsu,
  input  logic [ROB_W-1:0]  rob_id_from_lsb,
  input  logic [DATA_W-1:0] result_from_lsu,
  input  logic              rollback_flag_from_rob,
  output logic              alu_en_out,
  output logic [OP_W-1:0]   alu_op_out,
  output logic [DATA_W-1:0] alu_V1_out,
  output logic [DATA_W-1:0] alu_V2_out,
  output logic [DATA_W-1:0] alu_imm_out,
  output logic [DATA_W-1:0] alu_pos_out,
  output logic [ROB_W-1:0]  alu_rob_id_out,
  output logic              overflow_out
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [OP_W-1:0]    op_d  [RS_SIZE];
  logic [DATA_W-1:0]  v1_q  [RS_SIZE];
  logic [DATA_W-1:0]  v1_d  [RS_SIZE];
  logic [DATA_W-1:0]  v2_q  [RS_SIZE];
  logic [DATA_W-1:0]  v2_d  [RS_SIZE];
  logic [ROB_W-1:0]   q1_q  [RS_SIZE];
  logic [ROB_W-1:0]   q1_d  [RS_SIZE];
  logic [ROB_W-1:0]   q2_q  [RS_SIZE];
  logic [ROB_W-1:0]   q2_d  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [DATA_W-1:0]  imm_d [RS_SIZE];
  logic [DATA_W-1:0]  pos_q [RS_SIZE];
  logic [DATA_W-1:0]  pos_d [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];

  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              alu_en_q, alu_en_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_v1_q, alu_v1_d;
  logic [DATA_W-1:0] alu_v2_q, alu_v2_d;
  logic [DATA_W-1:0] alu_imm_q, alu_imm_d;
  logic [DATA_W-1:0] alu_pos_q, alu_pos_d;
  logic [ROB_W-1:0]  alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0] ready;
  logic               issue_any, free_any, bypass, write;
  logic [IDX_W-1:0]   issue_idx, free_idx;
  logic [ROB_W-1:0]   disp_q1, disp_q2;
  logic [DATA_W-1:0]  disp_v1, disp_v2;

  // Tag 0 never matches because only pending operands (q != 0) are compared.
  function automatic logic [ROB_W+DATA_W-1:0] snoop(input logic [ROB_W-1:0] q,
                                                    input logic [DATA_W-1:0] v);
    logic [ROB_W+DATA_W-1:0] r;
    r = {q, v};
    if (q != '0) begin
      if (enable_from_alu && rob_id_from_alu == q)
        r = {{ROB_W{1'b0}}, result_from_alu};
      else if (enable_from_lsu && rob_id_from_lsb == q)
        r = {{ROB_W{1'b0}}, result_from_lsu};
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
    assign ready[gi] = valid_q[gi] && (q1_q[gi] == '0) && (q2_q[gi] == '0);
  end

  // Descending scans leave the lowest matching index in place.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    {disp_q1, disp_v1} = snoop(Q1_from_dispatcher, V1_from_dispatcher);
    {disp_q2, disp_v2} = snoop(Q2_from_dispatcher, V2_from_dispatcher);
  end

`ifdef RS_BYPASS_EN
  assign bypass = enable_from_dispatcher && (disp_q1 == '0) && (disp_q2 == '0) && !issue_any;
`else
  assign bypass = 1'b0;
`endif
  assign write = enable_from_dispatcher && free_any && !bypass;

  always_comb begin
    valid_d    = valid_q;
    op_d       = op_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    q1_d       = q1_q;
    q2_d       = q2_q;
    imm_d      = imm_q;
    pos_d      = pos_q;
    rob_d      = rob_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    alu_en_d   = 1'b0;
    alu_op_d   = alu_op_q;
    alu_v1_d   = alu_v1_q;
    alu_v2_d   = alu_v2_q;
    alu_imm_d  = alu_imm_q;
    alu_pos_d  = alu_pos_q;
    alu_rob_d  = alu_rob_q;
    if (rdy_in && rollback_flag_from_rob) begin
      valid_d = '0;
      count_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i]);
        {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i]);
      end
      if (issue_any) begin
        valid_d[issue_idx] = 1'b0;
        alu_en_d  = 1'b1;
        alu_op_d  = op_q[issue_idx];
        alu_v1_d  = v1_q[issue_idx];
        alu_v2_d  = v2_q[issue_idx];
        alu_imm_d = imm_q[issue_idx];
        alu_pos_d = pos_q[issue_idx];
        alu_rob_d = rob_q[issue_idx];
      end
      if (bypass) begin
        alu_en_d  = 1'b1;
        alu_op_d  = op_enum_from_dispatcher;
        alu_v1_d  = disp_v1;
        alu_v2_d  = disp_v2;
        alu_imm_d = imm_from_dispatcher;
        alu_pos_d = inst_pos_from_dispatcher;
        alu_rob_d = rob_id_from_dispatcher;
      end
      if (write) begin
        valid_d[free_idx] = 1'b1;
        op_d[free_idx]    = op_enum_from_dispatcher;
        v1_d[free_idx]    = disp_v1;
        v2_d[free_idx]    = disp_v2;
        q1_d[free_idx]    = disp_q1;
        q2_d[free_idx]    = disp_q2;
        imm_d[free_idx]   = imm_from_dispatcher;
        pos_d[free_idx]   = inst_pos_from_dispatcher;
        rob_d[free_idx]   = rob_id_from_dispatcher;
      end
      count_d = count_q + CNT_W'(write) - CNT_W'(issue_any);
      if (enable_from_dispatcher && !free_any && !bypass)
        overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      alu_v1_q   <= '0;
      alu_v2_q   <= '0;
      alu_imm_q  <= '0;
      alu_pos_q  <= '0;
      alu_rob_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        imm_q[i] <= '0;
        pos_q[i] <= '0;
        rob_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      op_q       <= op_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      imm_q      <= imm_d;
      pos_q      <= pos_d;
      rob_q      <= rob_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      alu_v1_q   <= alu_v1_d;
      alu_v2_q   <= alu_v2_d;
      alu_imm_q  <= alu_imm_d;
      alu_pos_q  <= alu_pos_d;
      alu_rob_q  <= alu_rob_d;
    end
  end

  assign is_full_to_dispatcher = (count_q >= CNT_W'(RS_SIZE - 1));
  assign alu_en_out     = alu_en_q && rdy_in;
  assign alu_op_out     = alu_op_q;
  assign alu_V1_out     = alu_v1_q;
  assign alu_V2_out     = alu_v2_q;
  assign alu_imm_out    = alu_imm_q;
  assign alu_pos_out    = alu_pos_q;
  assign alu_rob_id_out = alu_rob_q;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: stimulus pushes expected issues, a negedge monitor checks them.
module tb_reservation_station;
  localparam int RS_SIZE = 16;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 6;
  localparam int DATA_W  = 32;
`ifdef RS_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic d_en;
  logic [OP_W-1:0] d_op;
  logic [DATA_W-1:0] d_v1, d_v2, d_imm, d_pos;
  logic [ROB_W-1:0] d_q1, d_q2, d_rob;
  logic a_en, l_en, rollback;
  logic [ROB_W-1:0] a_tag, l_tag;
  logic [DATA_W-1:0] a_val, l_val;
  logic is_full, alu_en_out, overflow;
  logic [OP_W-1:0] alu_op;
  logic [DATA_W-1:0] alu_v1, alu_v2, alu_imm, alu_pos;
  logic [ROB_W-1:0] alu_rob;

  reservation_station #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .enable_from_dispatcher(d_en), .op_enum_from_dispatcher(d_op),
    .V1_from_dispatcher(d_v1), .V2_from_dispatcher(d_v2),
    .Q1_from_dispatcher(d_q1), .Q2_from_dispatcher(d_q2),
    .imm_from_dispatcher(d_imm), .inst_pos_from_dispatcher(d_pos),
    .rob_id_from_dispatcher(d_rob), .is_full_to_dispatcher(is_full),
    .enable_from_alu(a_en), .rob_id_from_alu(a_tag), .result_from_alu(a_val),
    .enable_from_lsu(l_en), .rob_id_from_lsb(l_tag), .result_from_lsu(l_val),
    .rollback_flag_from_rob(rollback),
    .alu_en_out(alu_en_out), .alu_op_out(alu_op), .alu_V1_out(alu_v1), .alu_V2_out(alu_v2),
    .alu_imm_out(alu_imm), .alu_pos_out(alu_pos), .alu_rob_id_out(alu_rob),
    .overflow_out(overflow)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1, v2, imm, pos;
    logic [ROB_W-1:0]  rob;
    int unsigned       at;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && alu_en_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 64'(alu_en_out), 64'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("issue_edge", 64'(edge_cnt), 64'(cur.at));
        chk("issue_op",   64'(alu_op),   64'(cur.op));
        chk("issue_v1",   64'(alu_v1),   64'(cur.v1));
        chk("issue_v2",   64'(alu_v2),   64'(cur.v2));
        chk("issue_imm",  64'(alu_imm),  64'(cur.imm));
        chk("issue_pos",  64'(alu_pos),  64'(cur.pos));
        chk("issue_rob",  64'(alu_rob),  64'(cur.rob));
        $display("issue rob=%0d v1=%0h v2=%0h pos=%0h at edge %0d", alu_rob, alu_v1, alu_v2, alu_pos, edge_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_en = 0; d_op = '0; d_v1 = '0; d_v2 = '0; d_q1 = '0; d_q2 = '0;
    d_imm = '0; d_pos = '0; d_rob = '0;
    a_en = 0; a_tag = '0; a_val = '0; l_en = 0; l_tag = '0; l_val = '0;
    rollback = 0;
  endtask

  task automatic drive(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                       input logic [ROB_W-1:0] q1, input logic [ROB_W-1:0] q2,
                       input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pos, input logic [ROB_W-1:0] rob);
    d_en = 1; d_op = op; d_v1 = v1; d_v2 = v2; d_q1 = q1; d_q2 = q2;
    d_imm = imm; d_pos = pos; d_rob = rob;
  endtask

  task automatic expect_issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                              input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pos,
                              input logic [ROB_W-1:0] rob, input int unsigned at);
    exp_t e;
    e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pos = pos; e.rob = rob; e.at = at;
    exp_q.push_back(e);
  endtask

  // Dispatches n entries all waiting on tag; full must track the count exactly.
  task automatic fill(input int n, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(6'd5, 32'h0, DATA_W'(i), tag, 4'd0, base + DATA_W'(i), base + DATA_W'(i), ROB_W'(i % 15 + 1));
      tick();
      chk("full_during_fill", 64'(is_full), 64'((i + 1) >= RS_SIZE - 1));
    end
    d_en = 0;
  endtask

  task automatic drain(input int n, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] val,
                       input logic [DATA_W-1:0] base);
    int unsigned k;
    k = edge_cnt;
    a_en = 1; a_tag = tag; a_val = val;
    for (int i = 0; i < n; i++)
      expect_issue(6'd5, val, DATA_W'(i), base + DATA_W'(i), base + DATA_W'(i), ROB_W'(i % 15 + 1), k + 2 + i);
    tick();
    a_en = 0;
    repeat (n + 3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_alu_en", 64'(alu_en_out), 64'd0);
    chk("reset_full", 64'(is_full), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_alu_rob", 64'(alu_rob), 64'd0);
    rst_n = 1;
    tick();

    // Ready dispatch; a tag-0 ALU broadcast alongside must not disturb V1.
    k = edge_cnt;
    drive(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 32'h11, 32'h100, 4'd3);
    a_en = 1; a_tag = 4'd0; a_val = 32'hBAD;
    expect_issue(6'd1, 32'd5, 32'd7, 32'h11, 32'h100, 4'd3, k + LAT);
    tick();
    idle();
    repeat (4) tick();

    // Pending Q1 resolved later; ALU wins over LSU for the same tag.
    drive(6'd2, 32'hDEAD, 32'd2, 4'd4, 4'd0, 32'h22, 32'h104, 4'd5);
    tick();
    idle();
    repeat (3) tick();
    k = edge_cnt;
    a_en = 1; a_tag = 4'd4; a_val = 32'h10;
    l_en = 1; l_tag = 4'd4; l_val = 32'h99;
    expect_issue(6'd2, 32'h10, 32'd2, 32'h22, 32'h104, 4'd5, k + 2);
    tick();
    idle();
    repeat (3) tick();

    // LSU broadcast in the dispatch cycle is captured.
    k = edge_cnt;
    drive(6'd3, 32'd1, 32'hFFFF, 4'd0, 4'd6, 32'h33, 32'h108, 4'd7);
    l_en = 1; l_tag = 4'd6; l_val = 32'hAB;
    expect_issue(6'd3, 32'd1, 32'hAB, 32'h33, 32'h108, 4'd7, k + LAT);
    tick();
    idle();
    repeat (3) tick();

    // Two entries become ready together; slot 0 (rob 1) goes first.
    drive(6'd4, 32'h0, 32'h41, 4'd8, 4'd0, 32'h44, 32'h10C, 4'd1);
    tick();
    drive(6'd4, 32'h0, 32'h42, 4'd8, 4'd0, 32'h45, 32'h110, 4'd2);
    tick();
    idle();
    k = edge_cnt;
    a_en = 1; a_tag = 4'd8; a_val = 32'h77;
    expect_issue(6'd4, 32'h77, 32'h41, 32'h44, 32'h10C, 4'd1, k + 2);
    expect_issue(6'd4, 32'h77, 32'h42, 32'h45, 32'h110, 4'd2, k + 3);
    tick();
    idle();
    repeat (4) tick();

    // rdy low freezes state: a broadcast during the freeze is not captured.
    drive(6'd7, 32'h0, 32'h22, 4'd13, 4'd0, 32'h23, 32'h300, 4'd12);
    tick();
    idle();
    rdy = 0;
    a_en = 1; a_tag = 4'd13; a_val = 32'h55;
    tick();
    tick();
    idle();
    rdy = 1;
    repeat (3) tick();
    k = edge_cnt;
    a_en = 1; a_tag = 4'd13; a_val = 32'h66;
    expect_issue(6'd7, 32'h66, 32'h22, 32'h23, 32'h300, 4'd12, k + 2);
    tick();
    idle();
    repeat (3) tick();

    // Fill all 16 slots, overflow on the 17th, then drain in order.
    fill(16, 4'd9, 32'h200);
    chk("overflow_before_drop", 64'(overflow), 64'd0);
    drive(6'd6, 32'h0, 32'h0, 4'd9, 4'd0, 32'h0, 32'h2FF, 4'd14);
    tick();
    idle();
    chk("overflow_after_drop", 64'(overflow), 64'd1);
    chk("full_at_16", 64'(is_full), 64'd1);
    drain(16, 4'd9, 32'hC0DE, 32'h200);
    chk("full_after_drain", 64'(is_full), 64'd0);

    // Rollback with 8 pending and a simultaneous ready dispatch: all discarded.
    fill(8, 4'd10, 32'h400);
    drive(6'd1, 32'd9, 32'd9, 4'd0, 4'd0, 32'h0, 32'h500, 4'd15);
    rollback = 1;
    tick();
    idle();
    chk("full_after_rollback", 64'(is_full), 64'd0);
    chk("overflow_kept", 64'(overflow), 64'd1);
    a_en = 1; a_tag = 4'd10; a_val = 32'h1234;
    tick();
    idle();
    repeat (4) tick();
    fill(15, 4'd11, 32'h600);
    drain(15, 4'd11, 32'hFACE, 32'h600);

    repeat (3) tick();
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
